// File: rtl/mb_writeback.sv
// Macroblock writeback into an on-chip frame store, plus a neighbour fetch of
// the row above and the column left of a macroblock. Optional feature: MB_RANGE_CHECK_EN.
module mb_writeback #(
  parameter int unsigned LENGTH    = 16,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MB_SIZE_L = 4,
  parameter int unsigned MB_SIZE_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [12:0]            mbnumber,
  input  logic                   pix_valid,
  input  logic [7:0]             pix_data,
  output logic                   pix_ready,
  output logic                   done,
  input  logic                   nbr_req,
  input  logic [12:0]            nbr_mbnumber,
  output logic [8*MB_SIZE_W-1:0] toppixels,
  output logic [8*MB_SIZE_L-1:0] leftpixels,
  output logic                   nbr_valid
`ifdef MB_RANGE_CHECK_EN
  ,
  output logic                   err
`endif
);

  localparam int unsigned NPIX = LENGTH * WIDTH;
  localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned MPR  = WIDTH / MB_SIZE_W;
  localparam int unsigned JW   = $clog2(MB_SIZE_L);
  localparam int unsigned KW   = $clog2(MB_SIZE_W);
`ifdef MB_RANGE_CHECK_EN
  localparam int unsigned NMB  = (LENGTH / MB_SIZE_L) * MPR;
`endif

  typedef enum logic [1:0] {IDLE, WRITE, NBR} state_t;

  state_t          state, state_n;
  logic [31:0]     row_q, col_q;
  logic [JW-1:0]   j_q;
  logic [KW-1:0]   k_q;
  logic            start_bad, nbr_bad, last_pix, wr_en;
  logic [AW-1:0]   wr_addr;
  logic [8*MB_SIZE_W-1:0] top_c;
  logic [8*MB_SIZE_L-1:0] left_c;

  // Frame store powers up mid-grey and is deliberately outside the reset domain.
  logic [7:0] frame [NPIX] = '{default: 8'd128};

  function automatic logic [31:0] origin_row(input logic [12:0] mb);
    return (32'(mb) / MPR) * MB_SIZE_L;
  endfunction

  function automatic logic [31:0] origin_col(input logic [12:0] mb);
    return (32'(mb) % MPR) * MB_SIZE_W;
  endfunction

  // Addresses wrap modulo the store size so an oversized mbnumber stays in bounds.
  function automatic logic [AW-1:0] faddr(input logic [31:0] r, input logic [31:0] c);
    return AW'((r * WIDTH + c) % NPIX);
  endfunction

`ifdef MB_RANGE_CHECK_EN
  assign start_bad = (32'(mbnumber) >= NMB);
  assign nbr_bad   = (32'(nbr_mbnumber) >= NMB);
`else
  assign start_bad = 1'b0;
  assign nbr_bad   = 1'b0;
`endif

  assign pix_ready = (state == WRITE);
  assign last_pix  = (j_q == JW'(MB_SIZE_L - 1)) && (k_q == KW'(MB_SIZE_W - 1));
  assign wr_en     = (state == WRITE) && pix_valid;
  assign wr_addr   = faddr(row_q + 32'(j_q), col_q + 32'(k_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (!start_bad) state_n = WRITE;
        end else if (nbr_req && !nbr_bad) begin
          state_n = NBR;
        end
      end
      WRITE:   if (pix_valid && last_pix) state_n = IDLE;
      NBR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) frame[wr_addr] <= pix_data;
  end

  always_comb begin
    top_c  = '0;
    left_c = '0;
    for (int i = 0; i < int'(MB_SIZE_W); i++)
      top_c[8*i +: 8] = (row_q == 32'd0) ? 8'd128 : frame[faddr(row_q - 32'd1, col_q + 32'(i))];
    for (int i = 0; i < int'(MB_SIZE_L); i++)
      left_c[8*i +: 8] = (col_q == 32'd0) ? 8'd128 : frame[faddr(row_q + 32'(i), col_q - 32'd1)];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q      <= '0;
      col_q      <= '0;
      j_q        <= '0;
      k_q        <= '0;
      done       <= 1'b0;
      nbr_valid  <= 1'b0;
      toppixels  <= '0;
      leftpixels <= '0;
`ifdef MB_RANGE_CHECK_EN
      err        <= 1'b0;
`endif
    end else begin
      done      <= wr_en && last_pix;
      nbr_valid <= (state == NBR);
      case (state)
        IDLE: begin
          if (start) begin
            if (!start_bad) begin
              row_q <= origin_row(mbnumber);
              col_q <= origin_col(mbnumber);
              j_q   <= '0;
              k_q   <= '0;
            end
          end else if (nbr_req && !nbr_bad) begin
            row_q <= origin_row(nbr_mbnumber);
            col_q <= origin_col(nbr_mbnumber);
          end
`ifdef MB_RANGE_CHECK_EN
          if ((start && start_bad) || (!start && nbr_req && nbr_bad)) err <= 1'b1;
`endif
        end
        WRITE: begin
          if (pix_valid) begin
            if (k_q == KW'(MB_SIZE_W - 1)) begin
              k_q <= '0;
              j_q <= j_q + JW'(1);
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        NBR: begin
          toppixels  <= top_c;
          leftpixels <= left_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mb_writeback.sv
// Directed self-checking bench for mb_writeback (16x16 frame, 4x4 macroblocks).
module tb_mb_writeback;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [12:0] mbnumber = '0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        pix_ready;
  logic        done;
  logic        nbr_req = 1'b0;
  logic [12:0] nbr_mbnumber = '0;
  logic [31:0] toppixels;
  logic [31:0] leftpixels;
  logic        nbr_valid;
`ifdef MB_RANGE_CHECK_EN
  logic        err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mb_writeback dut (
    .clk(clk), .reset(reset), .start(start), .mbnumber(mbnumber),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .done(done), .nbr_req(nbr_req), .nbr_mbnumber(nbr_mbnumber),
    .toppixels(toppixels), .leftpixels(leftpixels), .nbr_valid(nbr_valid)
`ifdef MB_RANGE_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL reset_pix_ready: got %0b want 0", pix_ready); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", done); end
    n_cmp++; if (nbr_valid !== 1'b0) begin n_err++; $display("FAIL reset_nbr_valid: got %0b want 0", nbr_valid); end
    n_cmp++; if (toppixels !== 32'h0) begin n_err++; $display("FAIL reset_top: got %h want 00000000", toppixels); end
    n_cmp++; if (leftpixels !== 32'h0) begin n_err++; $display("FAIL reset_left: got %h want 00000000", leftpixels); end
    n_cmp++; if ({dut.j_q, dut.k_q} !== 4'h0) begin n_err++; $display("FAIL reset_counters: got %h want 0", {dut.j_q, dut.k_q}); end
`ifdef MB_RANGE_CHECK_EN
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0b want 0", err); end
`endif
    reset = 1'b0;
    step();
  endtask

  task automatic test_nbr_zero();
    nbr_mbnumber = 13'd0;
    nbr_req = 1'b1;
    step();
    nbr_req = 1'b0;
    n_cmp++; if (nbr_valid !== 1'b0) begin n_err++; $display("FAIL nbr0_early: got %0b want 0", nbr_valid); end
    step();
    n_cmp++; if (nbr_valid !== 1'b1) begin n_err++; $display("FAIL nbr0_valid: got %0b want 1", nbr_valid); end
    n_cmp++; if (toppixels !== 32'h80808080) begin n_err++; $display("FAIL nbr0_top: got %h want 80808080", toppixels); end
    n_cmp++; if (leftpixels !== 32'h80808080) begin n_err++; $display("FAIL nbr0_left: got %h want 80808080", leftpixels); end
    step();
    n_cmp++; if (nbr_valid !== 1'b0) begin n_err++; $display("FAIL nbr0_pulse: got %0b want 0", nbr_valid); end
  endtask

  // mb5: origin row 4, col 4; pixel (j,k) lands at (4+j)*16 + 4+k.
  task automatic test_write_b2b();
    int done_cnt = 0;
    int a;
    mbnumber = 13'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %0b want 1", pix_ready); end
    for (int p = 0; p < 16; p++) begin
      pix_valid = 1'b1;
      pix_data  = 8'(16 + p);
      step();
      if (done === 1'b1) done_cnt++;
      if (p < 15) begin
        n_cmp++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_mid p=%0d: got %0b want 1", p, pix_ready); end
      end
    end
    pix_valid = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %0b want 1", done); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_end: got %0b want 0", pix_ready); end
    step();
    if (done === 1'b1) done_cnt++;
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt); end
    for (int p = 0; p < 16; p++) begin
      a = (4 + p / 4) * 16 + 4 + p % 4;
      n_cmp++; if (dut.frame[a] !== 8'(16 + p)) begin n_err++; $display("FAIL b2b_frame[%0d]: got %h want %h", a, dut.frame[a], 8'(16 + p)); end
    end
  endtask

  task automatic test_nbr_after_write();
    nbr_mbnumber = 13'd9;
    nbr_req = 1'b1;
    step();
    nbr_req = 1'b0;
    step();
    n_cmp++; if (nbr_valid !== 1'b1) begin n_err++; $display("FAIL nbr9_valid: got %0b want 1", nbr_valid); end
    n_cmp++; if (toppixels !== 32'h1F1E1D1C) begin n_err++; $display("FAIL nbr9_top: got %h want 1f1e1d1c", toppixels); end
    n_cmp++; if (leftpixels !== 32'h80808080) begin n_err++; $display("FAIL nbr9_left: got %h want 80808080", leftpixels); end
    nbr_mbnumber = 13'd6;
    nbr_req = 1'b1;
    step();
    nbr_req = 1'b0;
    step();
    n_cmp++; if (leftpixels !== 32'h1F1B1713) begin n_err++; $display("FAIL nbr6_left: got %h want 1f1b1713", leftpixels); end
    n_cmp++; if (toppixels !== 32'h80808080) begin n_err++; $display("FAIL nbr6_top: got %h want 80808080", toppixels); end
    for (int c = 0; c < 5; c++) step();
    n_cmp++; if (leftpixels !== 32'h1F1B1713) begin n_err++; $display("FAIL nbr6_hold: got %h want 1f1b1713", leftpixels); end
  endtask

  // mb0 with pix_valid low then high alternately: 16 accepts need 32 WRITE cycles.
  task automatic test_toggle();
    int cyc = 0;
    int p = 0;
    int a;
    mbnumber = 13'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (pix_ready === 1'b1 && cyc < 100) begin
      pix_valid = (cyc % 2 == 1);
      pix_data  = 8'(16 + p);
      step();
      if (cyc % 2 == 1) p++;
      cyc++;
    end
    pix_valid = 1'b0;
    n_cmp++; if (cyc !== 32) begin n_err++; $display("FAIL toggle_cycles: got %0d want 32", cyc); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL toggle_done: got %0b want 1", done); end
    for (int q = 0; q < 16; q++) begin
      a = (q / 4) * 16 + q % 4;
      n_cmp++; if (dut.frame[a] !== 8'(16 + q)) begin n_err++; $display("FAIL toggle_frame[%0d]: got %h want %h", a, dut.frame[a], 8'(16 + q)); end
    end
    step();
  endtask

  // mb10: origin row 8, col 8; reset after the 7th accepted pixel.
  task automatic test_reset_mid_write();
    int a;
    mbnumber = 13'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int p = 0; p < 7; p++) begin
      pix_valid = 1'b1;
      pix_data  = 8'(8'h40 + p);
      step();
    end
    pix_data = 8'hEE;
    reset = 1'b1;
    #1;
    n_cmp++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_ready: got %0b want 0", pix_ready); end
    step();
    step();
    reset = 1'b0;
    step();
    step();
    pix_valid = 1'b0;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %0b want 0", done); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got %0b want 0", pix_ready); end
    for (int p = 0; p < 16; p++) begin
      a = (8 + p / 4) * 16 + 8 + p % 4;
      if (p < 7) begin
        n_cmp++; if (dut.frame[a] !== 8'(8'h40 + p)) begin n_err++; $display("FAIL rstmid_kept[%0d]: got %h want %h", a, dut.frame[a], 8'(8'h40 + p)); end
      end else begin
        n_cmp++; if (dut.frame[a] !== 8'h80) begin n_err++; $display("FAIL rstmid_untouched[%0d]: got %h want 80", a, dut.frame[a]); end
      end
    end
  endtask

  // mb15 (row 12, col 12) with a simultaneous nbr_req, and a stray start mid-stream.
  task automatic test_start_wins();
    int a;
    mbnumber = 13'd15;
    nbr_mbnumber = 13'd0;
    start = 1'b1;
    nbr_req = 1'b1;
    step();
    start = 1'b0;
    nbr_req = 1'b0;
    n_cmp++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL sw_ready: got %0b want 1", pix_ready); end
    step();
    n_cmp++; if (nbr_valid !== 1'b0) begin n_err++; $display("FAIL sw_nbr_dropped: got %0b want 0", nbr_valid); end
    for (int p = 0; p < 16; p++) begin
      pix_valid = 1'b1;
      pix_data  = 8'(8'h60 + p);
      start     = (p == 5);
      mbnumber  = 13'd0;
      step();
    end
    start = 1'b0;
    pix_valid = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL sw_done: got %0b want 1", done); end
    for (int p = 0; p < 16; p += 5) begin
      a = (12 + p / 4) * 16 + 12 + p % 4;
      n_cmp++; if (dut.frame[a] !== 8'(8'h60 + p)) begin n_err++; $display("FAIL sw_frame[%0d]: got %h want %h", a, dut.frame[a], 8'(8'h60 + p)); end
    end
    step();
  endtask

`ifdef MB_RANGE_CHECK_EN
  task automatic test_range_check();
    int done_cnt = 0;
    mbnumber = 13'd16;
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL range_err: got %0b want 1", err); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL range_ready: got %0b want 0", pix_ready); end
    for (int c = 0; c < 20; c++) begin
      pix_valid = 1'b1;
      step();
      if (done === 1'b1) done_cnt++;
    end
    pix_valid = 1'b0;
    n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL range_done: got %0d want 0", done_cnt); end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL range_sticky: got %0b want 1", err); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nbr_zero();
    test_write_b2b();
    test_nbr_after_write();
    test_toggle();
    test_reset_mid_write();
    test_start_wins();
`ifdef MB_RANGE_CHECK_EN
    test_range_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
